// File: rtl/logic_unit_mc_if.sv
// Handshake and operand/result bundle for the multi-cycle logic unit.
// The master side issues start with op/operands; the slave side (the unit)
// answers with busy/done and the registered result and flags.
interface logic_unit_mc_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] num1;
  logic [WIDTH-1:0] num2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             parity;

  modport master (
    output start, op, num1, num2,
    input  busy, done, result, zero, parity
  );

  modport slave (
    input  start, op, num1, num2,
    output busy, done, result, zero, parity
  );
endinterface

// File: rtl/logic_unit_mc.sv
// Multi-cycle bitwise logic unit.
// A WIDTH-bit operation is split into N = WIDTH/LANE slices, one slice per clock.
// Operands and op are latched when a start is accepted (IDLE or DONE); the
// running operation only ever looks at those latched copies. zero/parity are
// taken from the completed word on the same edge that writes the last slice,
// so they appear together with the done pulse.
module logic_unit_mc #(
  parameter int WIDTH = 32,
  parameter int LANE  = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  logic_unit_mc_if.slave bus
);

  localparam int N     = WIDTH / LANE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_NOR  = 3'b011;
  localparam logic [2:0] OP_XNOR = 3'b100;
  localparam logic [2:0] OP_ANDN = 3'b101;
  localparam logic [2:0] OP_PASS = 3'b110;
  localparam logic [2:0] OP_NOTA = 3'b111;

  // A lane width that does not tile the operand is a configuration error.
  generate
    if ((LANE < 1) || ((WIDTH % LANE) != 0)) begin : g_bad_lane
      $error("logic_unit_mc: WIDTH must be a non-zero multiple of LANE");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Per-slice logic function; slices are independent, there is no carry.
  function automatic logic [LANE-1:0] logic_f(
    input logic [2:0]      op,
    input logic [LANE-1:0] a,
    input logic [LANE-1:0] b
  );
    logic [LANE-1:0] r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOR:  r = ~(a | b);
      OP_XNOR: r = ~(a ^ b);
      OP_ANDN: r = a & ~b;
      OP_PASS: r = a;
      OP_NOTA: r = ~a;
      default: r = {LANE{1'b0}};
    endcase
    return r;
  endfunction

  // Even-parity bit of a full word (XOR reduction).
  function automatic logic parity_f(input logic [WIDTH-1:0] w);
    return ^w;
  endfunction

  state_t           state_r;
  state_t           state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       op_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] result_r;
  logic             zero_r;
  logic             parity_r;
  logic             busy_r;
  logic             done_r;

  logic [LANE-1:0]  a_slice_s;
  logic [LANE-1:0]  b_slice_s;
  logic [LANE-1:0]  new_slice_s;
  logic [WIDTH-1:0] word_s;
  logic             accept_s;

  // A start is only honoured when no slices are in flight.
  always_comb begin
    accept_s = 1'b0;
    if ((state_r != RUN) && bus.start) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic; DONE can chain straight into another RUN.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == CNT_LAST) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        if (accept_s) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Select the operand slices addressed by the slice counter.
  always_comb begin
    a_slice_s = {LANE{1'b0}};
    b_slice_s = {LANE{1'b0}};
    for (int i = 0; i < N; i++) begin
      if (cnt_r == CNT_W'(i)) begin
        a_slice_s = a_r[i*LANE +: LANE];
        b_slice_s = b_r[i*LANE +: LANE];
      end else begin
        a_slice_s = a_slice_s;
        b_slice_s = b_slice_s;
      end
    end
    new_slice_s = logic_f(op_r, a_slice_s, b_slice_s);
  end

  // Result word with the current slice replaced; untouched slices keep old data.
  always_comb begin
    word_s = result_r;
    for (int i = 0; i < N; i++) begin
      if (cnt_r == CNT_W'(i)) begin
        word_s[i*LANE +: LANE] = new_slice_s;
      end else begin
        word_s[i*LANE +: LANE] = result_r[i*LANE +: LANE];
      end
    end
  end

  // Datapath: operand latching, slice write-back, flags and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r    <= {CNT_W{1'b0}};
      op_r     <= 3'b000;
      a_r      <= {WIDTH{1'b0}};
      b_r      <= {WIDTH{1'b0}};
      result_r <= {WIDTH{1'b0}};
      zero_r   <= 1'b0;
      parity_r <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      busy_r <= (state_s == RUN);
      done_r <= (state_s == DONE);
      case (state_r)
        IDLE, DONE: begin
          if (accept_s) begin
            op_r  <= bus.op;
            a_r   <= bus.num1;
            b_r   <= bus.num2;
            cnt_r <= {CNT_W{1'b0}};
          end
        end
        RUN: begin
          result_r <= word_s;
          if (cnt_r == CNT_LAST) begin
            cnt_r    <= {CNT_W{1'b0}};
            zero_r   <= (word_s == {WIDTH{1'b0}});
            parity_r <= parity_f(word_s);
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          cnt_r <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.result = result_r;
  assign bus.zero   = zero_r;
  assign bus.parity = parity_r;

endmodule

// File: tb/tb_logic_unit_mc.sv
// Directed testbench for logic_unit_mc: a 32/8 instance for the handshake,
// latency, ignore-while-busy, back-to-back and reset cases, plus a 16/16
// instance for the single-cycle configuration and an op-table sweep.
module tb_logic_unit_mc;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   done_seen;

  logic_unit_mc_if #(.WIDTH(32)) bus32 ();
  logic_unit_mc_if #(.WIDTH(16)) bus16 ();

  logic_unit_mc #(.WIDTH(32), .LANE(8)) dut32 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus32)
  );

  logic_unit_mc #(.WIDTH(16), .LANE(16)) dut16 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus16)
  );

  always #5 clk = ~clk;

  logic [15:0] tab_res [8] = '{16'h0F00, 16'hFF0E, 16'hF00E, 16'h00F1,
                               16'h0FF1, 16'hF000, 16'hFF00, 16'h00FF};
  logic        tab_par [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic start32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus32.start = 1'b1;
    bus32.op    = op;
    bus32.num1  = a;
    bus32.num2  = b;
    tick();
    bus32.start = 1'b0;
  endtask

  task automatic start16(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    bus16.start = 1'b1;
    bus16.op    = op;
    bus16.num1  = a;
    bus16.num2  = b;
    tick();
    bus16.start = 1'b0;
  endtask

  // Four busy cycles after acceptance, then the edge that enters DONE.
  task automatic run32(input string tag);
    for (int i = 0; i < 4; i++) begin
      check({tag, "_busy"}, {31'd0, bus32.busy}, 32'd1);
      check({tag, "_nodone"}, {31'd0, bus32.done}, 32'd0);
      tick();
    end
  endtask

  task automatic flags32(input string tag, input logic [31:0] res, input logic z, input logic p);
    check({tag, "_done"}, {31'd0, bus32.done}, 32'd1);
    check({tag, "_busy_low"}, {31'd0, bus32.busy}, 32'd0);
    check({tag, "_result"}, bus32.result, res);
    check({tag, "_zero"}, {31'd0, bus32.zero}, {31'd0, z});
    check({tag, "_parity"}, {31'd0, bus32.parity}, {31'd0, p});
  endtask

  initial begin
    rst_n       = 1'b0;
    bus32.start = 1'b0;
    bus32.op    = 3'b000;
    bus32.num1  = 32'h0;
    bus32.num2  = 32'h0;
    bus16.start = 1'b0;
    bus16.op    = 3'b000;
    bus16.num1  = 16'h0;
    bus16.num2  = 16'h0;
    tick();
    tick();
    check("rst_busy", {31'd0, bus32.busy}, 32'd0);
    check("rst_done", {31'd0, bus32.done}, 32'd0);
    check("rst_result", bus32.result, 32'h0);
    check("rst_zero", {31'd0, bus32.zero}, 32'd0);
    check("rst_parity", {31'd0, bus32.parity}, 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: XOR with mixed slices
    start32(3'b010, 32'hFFFF0000, 32'h0F0F0F0F);
    run32("t1");
    flags32("t1", 32'hF0F00F0F, 1'b0, 1'b0);
    tick();
    check("t1_done_pulse", {31'd0, bus32.done}, 32'd0);

    // 2: XOR of equal operands gives zero
    start32(3'b010, 32'h12345678, 32'h12345678);
    run32("t2");
    flags32("t2", 32'h00000000, 1'b1, 1'b0);
    tick();
    check("t2_done_single", {31'd0, bus32.done}, 32'd0);
    check("t2_idle", {31'd0, bus32.busy}, 32'd0);

    // 3: AND, with a start pulse during RUN that must be ignored
    start32(3'b000, 32'h00000001, 32'h00000003);
    tick();
    bus32.start = 1'b1;
    bus32.op    = 3'b001;
    bus32.num1  = 32'hFFFFFFFF;
    bus32.num2  = 32'hA5A5A5A5;
    tick();
    bus32.start = 1'b0;
    check("t3_busy_mid", {31'd0, bus32.busy}, 32'd1);
    tick();
    check("t3_busy_late", {31'd0, bus32.busy}, 32'd1);
    tick();
    flags32("t3", 32'h00000001, 1'b0, 1'b1);
    tick();
    check("t3_no_rerun", {31'd0, bus32.busy}, 32'd0);
    check("t3_no_redone", {31'd0, bus32.done}, 32'd0);

    // 4: NOR, then a back-to-back NOT A accepted in the DONE cycle
    start32(3'b011, 32'h00000000, 32'h00000000);
    run32("t4a");
    flags32("t4a", 32'hFFFFFFFF, 1'b0, 1'b0);
    start32(3'b111, 32'hFFFFFFFF, 32'h00000000);
    run32("t4b");
    flags32("t4b", 32'h00000000, 1'b1, 1'b0);
    tick();

    // 5: reset two cycles into a run aborts everything
    start32(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF);
    tick();
    tick();
    check("t5_busy_before", {31'd0, bus32.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5_busy", {31'd0, bus32.busy}, 32'd0);
    check("t5_done", {31'd0, bus32.done}, 32'd0);
    check("t5_result", bus32.result, 32'h0);
    check("t5_zero", {31'd0, bus32.zero}, 32'd0);
    check("t5_parity", {31'd0, bus32.parity}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus32.done === 1'b1) done_seen++;
    end
    check("t5_no_done", 32'(done_seen), 32'd0);
    start32(3'b001, 32'h80000000, 32'h00000000);
    run32("t5r");
    flags32("t5r", 32'h80000000, 1'b0, 1'b1);
    tick();

    // 6: single-slice configuration, A&~B
    start16(3'b101, 16'hFF00, 16'h0F0F);
    check("t6_busy", {31'd0, bus16.busy}, 32'd1);
    check("t6_nodone", {31'd0, bus16.done}, 32'd0);
    tick();
    check("t6_done", {31'd0, bus16.done}, 32'd1);
    check("t6_result", {16'd0, bus16.result}, 32'h0000F000);
    check("t6_zero", {31'd0, bus16.zero}, 32'd0);
    check("t6_parity", {31'd0, bus16.parity}, 32'd0);
    tick();

    // op table on the single-slice unit, A=FF00 B=0F0E
    for (int k = 0; k < 8; k++) begin
      start16(3'(k), 16'hFF00, 16'h0F0E);
      tick();
      check($sformatf("op%0d_done", k), {31'd0, bus16.done}, 32'd1);
      check($sformatf("op%0d_result", k), {16'd0, bus16.result}, {16'd0, tab_res[k]});
      check($sformatf("op%0d_parity", k), {31'd0, bus16.parity}, {31'd0, tab_par[k]});
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
